fp_mul_pipe: RTL and testbench

- Parametrised, fully pipelined floating-point multiplier. It succeeds the fixed two-stage bfloat16 multiplier.
- Generalises the format widths and adds a valid/ready handshake with back-pressure, per-operation rounding mode (truncate or round-to-nearest-even), exception flags and a sideband tag.
- Sits in the same floating-point library as the other multipliers and adders, and is instantiated by generated datapaths.

---
 rtl/fp_mul_pipe.sv | 180 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready back-pressure, per-operation
// truncate / round-to-nearest-even rounding, {invalid, overflow, underflow} flags and a tag.
module fp_mul_pipe #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned FRAC_W = 7,
   parameter int unsigned TAG_W  = 4,
   localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_rnd,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       out_flags
);

   localparam int unsigned MW = FRAC_W + 1;
   localparam int unsigned PW = 2 * MW;
   localparam int unsigned SW = EXP_W + 2;
   localparam logic [SW-1:0] BIAS_V = SW'(2 ** (EXP_W - 1) - 1);
   localparam logic [SW-1:0] EMAX_V = SW'(2 ** EXP_W - 1);

   typedef enum logic [1:0] {ClsNum, ClsZero, ClsInf, ClsNan} cls_e;

   logic adv;

   // Operand fields
   logic              a_sign, b_sign;
   logic [EXP_W-1:0]  a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   // Stage 1: decode
   logic              s1_valid_q;
   logic              s1_sign_d, s1_sign_q;
   logic [MW-1:0]     s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
   logic [SW-1:0]     s1_exp_d, s1_exp_q;
   cls_e              s1_cls_d, s1_cls_q;
   logic              s1_rnd_q;
   logic [TAG_W-1:0]  s1_tag_q;

   // Stage 2: multiply
   logic              s2_valid_q;
   logic              s2_sign_q;
   logic [PW-1:0]     s2_prod_d, s2_prod_q;
   logic [SW-1:0]     s2_exp_q;
   cls_e              s2_cls_q;
   logic              s2_rnd_q;
   logic [TAG_W-1:0]  s2_tag_q;

   // Stage 3: normalise, round, pack
   logic [PW-2:0]     norm_low;
   logic [SW-1:0]     exp_n, exp_r;
   logic [FRAC_W-1:0] frac_t;
   logic              guard, sticky, round_up;
   logic [FRAC_W:0]   frac_sum;
   logic              out_valid_q;
   logic [W-1:0]      out_res_d, out_res_q;
   logic [2:0]        out_flags_d, out_flags_q;
   logic [TAG_W-1:0]  out_tag_q;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv && !rst;

   assign a_sign = in_a[W-1];
   assign b_sign = in_b[W-1];
   assign a_exp  = in_a[W-2 -: EXP_W];
   assign b_exp  = in_b[W-2 -: EXP_W];
   assign a_frac = in_a[FRAC_W-1:0];
   assign b_frac = in_b[FRAC_W-1:0];

   assign a_zero = ~|a_exp;
   assign b_zero = ~|b_exp;
   assign a_inf  = (&a_exp) & ~|a_frac;
   assign b_inf  = (&b_exp) & ~|b_frac;
   assign a_nan  = (&a_exp) & |a_frac;
   assign b_nan  = (&b_exp) & |b_frac;

   always_comb begin
      s1_sign_d = a_sign ^ b_sign;
      s1_ma_d   = {1'b1, a_frac};
      s1_mb_d   = {1'b1, b_frac};
      s1_exp_d  = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_V;
      s1_cls_d  = ClsNum;
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
         s1_cls_d = ClsNan;
      end else if (a_inf || b_inf) begin
         s1_cls_d = ClsInf;
      end else if (a_zero || b_zero) begin
         s1_cls_d = ClsZero;
      end
   end

   assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

   always_comb begin
      // Align so the leading one sits just above norm_low; the dropped zero joins the sticky bits.
      norm_low    = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
      exp_n       = s2_exp_q + {{(SW-1){1'b0}}, s2_prod_q[PW-1]};
      frac_t      = norm_low[PW-2 -: FRAC_W];
      guard       = norm_low[PW-2-FRAC_W];
      sticky      = |norm_low[PW-3-FRAC_W:0];
      round_up    = s2_rnd_q & guard & (sticky | frac_t[0]);
      frac_sum    = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
      exp_r       = exp_n + {{(SW-1){1'b0}}, frac_sum[FRAC_W]};
      out_res_d   = {s2_sign_q, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
      out_flags_d = 3'b000;
      unique case (s2_cls_q)
         ClsNan: begin
            out_res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            out_flags_d = 3'b100;
         end
         ClsInf: begin
            out_res_d = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         end
         ClsZero: begin
            out_res_d = {s2_sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
         end
         default: begin
            if (exp_r[SW-1] || (exp_r == '0)) begin
               out_res_d   = {s2_sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
               out_flags_d = 3'b001;
            end else if (exp_r >= EMAX_V) begin
               out_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               out_flags_d = 3'b010;
            end
         end
      endcase
   end

   // Valids and result registers are reset; intermediate data only moves when the pipe advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         out_tag_q   <= '0;
         out_flags_q <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         out_res_q   <= out_res_d;
         out_tag_q   <= s2_tag_q;
         out_flags_q <= out_flags_d;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sign_q <= s1_sign_d;
         s1_ma_q   <= s1_ma_d;
         s1_mb_q   <= s1_mb_d;
         s1_exp_q  <= s1_exp_d;
         s1_cls_q  <= s1_cls_d;
         s1_rnd_q  <= in_rnd;
         s1_tag_q  <= in_tag;
         s2_sign_q <= s1_sign_q;
         s2_prod_q <= s2_prod_d;
         s2_exp_q  <= s1_exp_q;
         s2_cls_q  <= s1_cls_q;
         s2_rnd_q  <= s1_rnd_q;
         s2_tag_q  <= s1_tag_q;
      end
   end

   assign out_valid = out_valid_q && !rst;
   assign out_res   = rst ? '0 : out_res_q;
   assign out_tag   = rst ? '0 : out_tag_q;
   assign out_flags = rst ? 3'b000 : out_flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors, randomized stream against an
// arithmetic reference model, back-pressure and reset behaviour.
module tb_fp_mul_pipe;

   localparam int EW   = 8;
   localparam int FW   = 7;
   localparam int TW   = 4;
   localparam int W    = 1 + EW + FW;
   localparam int BIAS = 127;
   localparam int EMAX = 255;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_rnd;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_res;
   logic [TW-1:0] out_tag;
   logic [2:0]    out_flags;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0]  res;
      logic [2:0]    fl;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;

   exp_t q[$];

   fp_mul_pipe #(
      .EXP_W (EW),
      .FRAC_W(FW),
      .TAG_W (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_rnd   (in_rnd),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_res  (out_res),
      .out_tag  (out_tag),
      .out_flags(out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] fp(input int s, input int e, input int f);
      return {1'(s), EW'(e), FW'(f)};
   endfunction

   // Reference: exact integer product, then normalise/round by arithmetic on the remainder.
   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic rnd);
      int   ea, eb, fa, fb, p, e, sh, m, rem, half;
      logic s, an, bn, ai, bi, az, bz;
      s  = a[W-1] ^ b[W-1];
      ea = int'(a[W-2:FW]);
      eb = int'(b[W-2:FW]);
      fa = int'(a[FW-1:0]);
      fb = int'(b[FW-1:0]);
      an = (ea == EMAX) && (fa != 0);
      bn = (eb == EMAX) && (fb != 0);
      ai = (ea == EMAX) && (fa == 0);
      bi = (eb == EMAX) && (fb == 0);
      az = (ea == 0);
      bz = (eb == 0);
      if (an || bn || (az && bi) || (ai && bz)) return {3'b100, 1'b0, EW'(EMAX), FW'(1 << (FW-1))};
      if (ai || bi) return {3'b000, s, EW'(EMAX), FW'(0)};
      if (az || bz) return {3'b000, s, EW'(0), FW'(0)};
      p = ((1 << FW) + fa) * ((1 << FW) + fb);
      e = ea + eb - BIAS;
      if (p >= (1 << (2 * FW + 1))) begin
         e++;
         sh = FW + 1;
      end else begin
         sh = FW;
      end
      m    = p >> sh;
      rem  = p - (m << sh);
      half = 1 << (sh - 1);
      if (rnd && (rem > half || (rem == half && (m % 2) == 1))) m++;
      if (m == (2 << FW)) begin
         m = 1 << FW;
         e++;
      end
      if (e <= 0) return {3'b001, s, EW'(0), FW'(0)};
      if (e >= EMAX) return {3'b010, s, EW'(EMAX), FW'(0)};
      return {3'b000, s, EW'(e), FW'(m - (1 << FW))};
   endfunction

   function automatic logic [W-1:0] rand_op();
      int sel, e, f;
      sel = $urandom_range(0, 11);
      f   = $urandom_range(0, (1 << FW) - 1);
      if (sel == 0) e = 0;
      else if (sel == 1) begin
         e = EMAX;
         if ($urandom_range(0, 1) == 0) f = 0;
      end else if (sel <= 4) e = $urandom_range(1, EMAX - 1);
      else e = $urandom_range(64, 190);
      return fp($urandom_range(0, 1), e, f);
   endfunction

   task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic rm, input logic [TW-1:0] t,
                              input logic ordy, output logic xfer, output logic ov,
                              output logic ir, output logic [W-1:0] res,
                              output logic [TW-1:0] otag, output logic [2:0] ofl);
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_rnd    = rm;
      in_tag    = t;
      out_ready = ordy;
      #1;
      ir   = in_ready;
      ov   = out_valid;
      xfer = v && in_ready;
      res  = out_res;
      otag = out_tag;
      ofl  = out_flags;
   endtask

   task automatic test_reset();
      logic xf, ov, ir;
      logic [W-1:0] res;
      logic [TW-1:0] tg;
      logic [2:0] fl;
      int spurious;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
         checks++;
         if (ov !== 1'b0 || ir !== 1'b0 || res !== '0 || tg !== '0 || fl !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold cyc%0d: valid=%b ready=%b res=%h tag=%h flags=%b, want 0s",
                     i, ov, ir, res, tg, fl);
         end
      end
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
      checks++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", ir, ov);
      end
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
         if (ov !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         failures++;
         $display("FAIL reset_idle: spurious out_valid count=%0d, want 0", spurious);
      end
   endtask

   task automatic test_directed();
      localparam int ND = 15;
      logic [W-1:0] da[ND], db[ND], dr[ND];
      logic [2:0]   df[ND];
      logic         dm[ND];
      logic xf, ov, ir;
      logic [W-1:0] res;
      logic [TW-1:0] tg;
      logic [2:0] fl;
      exp_t e;
      int i, idx, budget;
      da[0]  = fp(0, 127, 0);  db[0]  = fp(0, 127, 0);  dm[0]  = 0; dr[0]  = fp(0, 127, 0);
      da[1]  = fp(0, 127, 64); db[1]  = fp(0, 127, 64); dm[1]  = 0; dr[1]  = fp(0, 128, 16);
      da[2]  = fp(0, 127, 32); db[2]  = fp(0, 127, 32); dm[2]  = 1; dr[2]  = fp(0, 127, 72);
      da[3]  = fp(0, 126, 64); db[3]  = fp(0, 126, 64); dm[3]  = 0; dr[3]  = fp(0, 126, 16);
      da[4]  = fp(0, 127, 1);  db[4]  = fp(0, 127, 65); dm[4]  = 0; dr[4]  = fp(0, 127, 66);
      da[5]  = fp(0, 127, 1);  db[5]  = fp(0, 127, 65); dm[5]  = 1; dr[5]  = fp(0, 127, 67);
      da[6]  = fp(0, 127, 6);  db[6]  = fp(0, 127, 32); dm[6]  = 0; dr[6]  = fp(0, 127, 39);
      da[7]  = fp(0, 127, 6);  db[7]  = fp(0, 127, 32); dm[7]  = 1; dr[7]  = fp(0, 127, 40);
      da[8]  = fp(0, 127, 2);  db[8]  = fp(0, 127, 32); dm[8]  = 1; dr[8]  = fp(0, 127, 34);
      da[9]  = fp(0, 1, 0);    db[9]  = fp(0, 14, 0);   dm[9]  = 1; dr[9]  = fp(0, 0, 0);
      da[10] = fp(0, 192, 0);  db[10] = fp(0, 192, 0);  dm[10] = 1; dr[10] = fp(0, 255, 0);
      da[11] = fp(0, 0, 0);    db[11] = fp(0, 255, 0);  dm[11] = 1; dr[11] = fp(0, 255, 64);
      da[12] = fp(1, 127, 0);  db[12] = fp(0, 0, 0);    dm[12] = 1; dr[12] = fp(1, 0, 0);
      da[13] = fp(0, 127, 53); db[13] = fp(0, 127, 53); dm[13] = 1; dr[13] = fp(0, 128, 0);
      da[14] = fp(1, 255, 0);  db[14] = fp(0, 127, 0);  dm[14] = 0; dr[14] = fp(1, 255, 0);
      df = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
      q.delete();
      i = 0;
      budget = 0;
      while ((i < ND || q.size() > 0) && budget < 100) begin
         idx = (i < ND) ? i : 0;
         drive_cycle(1'b0, i < ND, da[idx], db[idx], dm[idx], TW'(idx), 1'b1,
                     xf, ov, ir, res, tg, fl);
         if (xf) begin
            q.push_back('{res: dr[idx], fl: df[idx], tag: TW'(idx), cyc: cyc});
            i++;
         end
         if (ov) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL directed_extra: unexpected result res=%h tag=%h", res, tg);
            end else begin
               e = q.pop_front();
               if (res !== e.res || fl !== e.fl || tg !== e.tag || (cyc - e.cyc) != 3) begin
                  failures++;
                  $display("FAIL directed_%0d: res=%h flags=%b tag=%h lat=%0d, want %h %b %h 3",
                           e.tag, res, fl, tg, cyc - e.cyc, e.res, e.fl, e.tag);
               end
            end
         end
         budget++;
      end
      checks++;
      if (i != ND || q.size() != 0) begin
         failures++;
         $display("FAIL directed_timeout: issued=%0d pending=%0d, want %0d 0", i, q.size(), ND);
      end
   endtask

   task automatic test_random();
      localparam int NOPS = 300;
      logic xf, ov, ir, ordy, pend, rm;
      logic [W-1:0] res, a, b;
      logic [TW-1:0] tg, t;
      logic [2:0] fl;
      exp_t e;
      logic [W+2:0] mr;
      int issued, budget;
      q.delete();
      issued = 0;
      budget = 0;
      pend   = 1'b0;
      a = '0; b = '0; rm = 1'b0; t = '0;
      while ((issued < NOPS || q.size() > 0) && budget < 4000) begin
         if (!pend && issued < NOPS && $urandom_range(0, 4) != 0) begin
            a    = rand_op();
            b    = rand_op();
            rm   = 1'($urandom_range(0, 1));
            t    = TW'($urandom);
            pend = 1'b1;
         end
         ordy = ($urandom_range(0, 3) != 0);
         drive_cycle(1'b0, pend, a, b, rm, t, ordy, xf, ov, ir, res, tg, fl);
         if (xf) begin
            mr = model(a, b, rm);
            q.push_back('{res: mr[W-1:0], fl: mr[W+2:W], tag: t, cyc: cyc});
            issued++;
            pend = 1'b0;
         end
         if (ov && ordy) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL random_extra: unexpected result res=%h tag=%h", res, tg);
            end else begin
               e = q.pop_front();
               if (res !== e.res || fl !== e.fl || tg !== e.tag) begin
                  failures++;
                  $display("FAIL random: res=%h flags=%b tag=%h, want %h %b %h",
                           res, fl, tg, e.res, e.fl, e.tag);
               end
            end
         end
         budget++;
      end
      checks++;
      if (issued != NOPS || q.size() != 0) begin
         failures++;
         $display("FAIL random_timeout: issued=%0d pending=%0d", issued, q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic xf, ov, ir, ordy, stalled, saw_low;
      logic [W-1:0] res, p_res;
      logic [TW-1:0] tg, p_tag;
      logic [2:0] fl, p_fl;
      logic [W-1:0] a[6], b[6];
      logic [W+2:0] mr;
      exp_t e;
      int i, k, retired;
      for (int j = 0; j < 6; j++) begin
         a[j] = fp(0, $urandom_range(100, 150), $urandom_range(0, 127));
         b[j] = fp($urandom_range(0, 1), $urandom_range(100, 150), $urandom_range(0, 127));
      end
      q.delete();
      i = 0; k = 0; retired = 0;
      stalled = 1'b0; saw_low = 1'b0;
      p_res = '0; p_tag = '0; p_fl = '0;
      while ((i < 6 || q.size() > 0) && k < 60) begin
         ordy = !(k >= 4 && k <= 8);
         drive_cycle(1'b0, i < 6, a[(i < 6) ? i : 0], b[(i < 6) ? i : 0], 1'b1, TW'(i), ordy,
                     xf, ov, ir, res, tg, fl);
         if (stalled) begin
            checks++;
            if (ov !== 1'b1 || res !== p_res || tg !== p_tag || fl !== p_fl) begin
               failures++;
               $display("FAIL b2b_hold k=%0d: valid=%b res=%h tag=%h flags=%b, want 1 %h %h %b",
                        k, ov, res, tg, fl, p_res, p_tag, p_fl);
            end
         end
         if (ov && !ordy) begin
            checks++;
            if (ir !== 1'b0) begin
               failures++;
               $display("FAIL b2b_in_ready k=%0d: in_ready=%b, want 0", k, ir);
            end
            saw_low = 1'b1;
         end
         if (xf) begin
            mr = model(a[i], b[i], 1'b1);
            q.push_back('{res: mr[W-1:0], fl: mr[W+2:W], tag: TW'(i), cyc: cyc});
            i++;
         end
         if (ov && ordy) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: duplicate or unexpected result tag=%h", tg);
            end else begin
               e = q.pop_front();
               retired++;
               if (res !== e.res || fl !== e.fl || tg !== e.tag) begin
                  failures++;
                  $display("FAIL b2b_order: res=%h flags=%b tag=%h, want %h %b %h",
                           res, fl, tg, e.res, e.fl, e.tag);
               end
            end
         end
         stalled = ov && !ordy;
         p_res = res; p_tag = tg; p_fl = fl;
         k++;
      end
      checks++;
      if (retired != 6 || !saw_low || q.size() != 0) begin
         failures++;
         $display("FAIL b2b_count: retired=%0d saw_stall=%b pending=%0d, want 6 1 0",
                  retired, saw_low, q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic xf, ov, ir;
      logic [W-1:0] res, a, b;
      logic [TW-1:0] tg;
      logic [2:0] fl;
      logic [W+2:0] mr;
      int sent, spurious, t0, lat;
      sent = 0;
      for (int j = 0; j < 3; j++) begin
         drive_cycle(1'b0, 1'b1, fp(0, 127, j), fp(0, 128, 3), 1'b0, TW'(j + 8), 1'b1,
                     xf, ov, ir, res, tg, fl);
         if (xf) sent++;
      end
      spurious = 0;
      for (int j = 0; j < 2; j++) begin
         drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
         if (ov !== 1'b0) spurious++;
      end
      for (int j = 0; j < 10; j++) begin
         drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
         if (ov !== 1'b0) spurious++;
      end
      checks++;
      if (sent != 3 || spurious != 0) begin
         failures++;
         $display("FAIL reset_mid_flush: sent=%0d spurious=%0d, want 3 0", sent, spurious);
      end
      a  = fp(1, 130, 45);
      b  = fp(0, 120, 99);
      mr = model(a, b, 1'b1);
      drive_cycle(1'b0, 1'b1, a, b, 1'b1, 4'hd, 1'b1, xf, ov, ir, res, tg, fl);
      t0  = cyc;
      lat = -1;
      for (int j = 0; j < 10 && lat < 0; j++) begin
         drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, xf, ov, ir, res, tg, fl);
         if (ov) lat = cyc - t0;
      end
      checks++;
      if (lat != 3 || res !== mr[W-1:0] || fl !== mr[W+2:W] || tg !== 4'hd) begin
         failures++;
         $display("FAIL reset_mid_next: lat=%0d res=%h flags=%b tag=%h, want 3 %h %b d",
                  lat, res, fl, tg, mr[W-1:0], mr[W+2:W]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_rnd    = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
